calc_dec: RTL and testbench
===========================

Name: calc_dec

Overview:
- Inverse of the calculator button encoder: accepts 4-bit ALU opcodes AL[3:0] and recovers the 3-bit button triple {A,B,C} that produced each one.
- Sits on the ALU-op path, where the opcode stream is checked and reported back: debug display and LED echo of the pressed buttons.
- Input side is a valid/ready stream; decode results are queued in a small output FIFO.
- Opcodes outside the legal set are flagged, counted, and latched in a sticky error bit.

Parameters:
- DEPTH, 2: output FIFO entries; power of two, at least 2.
- ERR_W, 8: width of the illegal-opcode counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_op is valid this cycle.
- in_ready  out  1  block can accept an opcode this cycle.
- in_op  in  4  ALU opcode AL[3:0].
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the FIFO head this cycle.
- out_abc  out  3  decoded {A,B,C}; A is the MSB.
- out_illegal  out  1  FIFO head came from an illegal opcode.
- err_cnt  out  ERR_W  saturating count of accepted illegal opcodes.
- err_sticky  out  1  set on any accepted illegal opcode.
- clr_err  in  1  clears err_cnt and err_sticky.

Behaviour:
- Decode table, opcode -> ABC: 0x2->000, 0x0->001, 0xD->010, 0x9->011, 0x6->100, 0x1->101, 0x7->110, 0xA->111.
- Any other opcode is illegal: abc=000, illegal=1.
- Accept condition: in_valid & in_ready.
  - On accept, {illegal, abc} is written to the FIFO tail.
  - The entry appears on the out_* ports 1 cycle later at the earliest; there is no combinational in->out path.
- in_ready = !full. Registered-FIFO semantics: no bypass, and no push while full, even if a pop occurs in the same cycle.
- Pop condition: out_valid & out_ready.
  - out_valid = !empty.
  - out_abc and out_illegal come from the head entry. When the FIFO is empty they hold 000 / 0.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and ordering is preserved.
- Pointers wrap modulo DEPTH. Occupancy count is clog2(DEPTH)+1 bits wide.
- out_ready while empty: ignored, no state change.
- Error counter:
  - Increments on each accepted illegal opcode and saturates at 2^ERR_W-1.
  - err_sticky is set on the same edge.
  - An illegal opcode presented while in_ready=0 is not counted.
- clr_err:
  - Alone: err_cnt=0, err_sticky=0 on the next edge.
  - Same cycle as an accepted illegal opcode: the new event wins, giving err_cnt=1, err_sticky=1.
- Reset, including mid-stream: FIFO emptied and pointers zeroed.
  - Values on the next edge: out_valid=0, in_ready=1, out_abc=000, out_illegal=0, err_cnt=0, err_sticky=0.
  - In-flight entries are discarded.
  - An input presented during rst is not accepted.

Decomposition:
- Package calc_pkg holds:
  - the eight legal opcode constants (OP_ABC_000 .. OP_ABC_111);
  - a 4-bit opcode typedef;
  - a packed entry typedef {illegal, abc[2:0]}.
- The encoder and calc_dec share these constants.
- Sub-module calc_dec_lut: purely combinational opcode -> {illegal, abc}. Instantiated once ahead of the FIFO write port.

Test Plan:
- Legal sweep: send all 8 legal opcodes back to back with out_ready=1 -> out_abc emits 000..111 in table order, each one cycle after its accept; out_illegal=0; err_cnt=0.
- Backpressure: out_ready=0, send 0x2,0x0,0xD -> the first two are accepted, and in_ready=0 on the third cycle. Raise out_ready -> 000, 001, 010 in order; 0xD is accepted once space frees.
- Illegal handling: send 0x3, then 0xF -> two entries with out_illegal=1 and abc=000; err_cnt=2; err_sticky=1.
- Clear collision: pulse clr_err in the same cycle as accepting 0xB -> err_cnt=1, err_sticky=1. Then clr_err alone -> 0, 0.
- Saturation: ERR_W=2, accept 5 illegal opcodes -> err_cnt=3.
- Reset mid-stream: FIFO full, assert rst for 1 cycle -> next cycle out_valid=0, in_ready=1, err_cnt=0. The first opcode sent after reset (0x7) emits 110.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcode constants and types for the calculator button encoder/decoder pair.
package calc_pkg;

  // 4-bit ALU opcode AL[3:0]
  typedef logic [3:0] opcode_t;

  // One decoded result: illegal flag above the {A,B,C} button triple (A is the MSB)
  typedef struct packed {
    logic       illegal;
    logic [2:0] abc;
  } entry_t;

  // Legal opcodes, named by the button triple that produces them
  localparam opcode_t OP_ABC_000 = 4'h2;
  localparam opcode_t OP_ABC_001 = 4'h0;
  localparam opcode_t OP_ABC_010 = 4'hD;
  localparam opcode_t OP_ABC_011 = 4'h9;
  localparam opcode_t OP_ABC_100 = 4'h6;
  localparam opcode_t OP_ABC_101 = 4'h1;
  localparam opcode_t OP_ABC_110 = 4'h7;
  localparam opcode_t OP_ABC_111 = 4'hA;

endpackage

// File: rtl/calc_dec_lut.sv
// Combinational opcode -> {illegal, abc} lookup. Unknown opcodes decode to abc=000 with illegal set.
module calc_dec_lut
  import calc_pkg::*;
(
  input  opcode_t op,
  output entry_t  entry
);

  // Reverse table of the button encoder
  always_comb begin
    entry = '{illegal: 1'b0, abc: 3'b000};
    case (op)
      OP_ABC_000: entry.abc = 3'b000;
      OP_ABC_001: entry.abc = 3'b001;
      OP_ABC_010: entry.abc = 3'b010;
      OP_ABC_011: entry.abc = 3'b011;
      OP_ABC_100: entry.abc = 3'b100;
      OP_ABC_101: entry.abc = 3'b101;
      OP_ABC_110: entry.abc = 3'b110;
      OP_ABC_111: entry.abc = 3'b111;
      default:    entry.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/calc_dec.sv
// Opcode stream decoder: decodes accepted opcodes into a small output FIFO and
// keeps a saturating count plus a sticky flag of illegal opcodes.
module calc_dec
  import calc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_abc,
  output logic             out_illegal,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky,
  input  logic             clr_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  entry_t           wr_entry;
  entry_t           head_entry;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             full, empty, push, pop;

  calc_dec_lut u_lut (
    .op    (opcode_t'(in_op)),
    .entry (wr_entry)
  );

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  // Push is gated on full alone: a pop in the same cycle does not open a slot early
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is masked while empty so stale storage never shows on the outputs
  assign head_entry  = empty ? entry_t'('0) : mem_q[rd_ptr_q];
  assign out_abc     = head_entry.abc;
  assign out_illegal = head_entry.illegal;
  assign err_cnt     = err_cnt_q;
  assign err_sticky  = err_sticky_q;

  // FIFO storage next state: write the decoded entry at the tail slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
    end
  end

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH (power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Error bookkeeping: clear first, so a same-cycle illegal accept lands on a zeroed counter
  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (clr_err) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end
    if (push && wr_entry.illegal) begin
      err_sticky_d = 1'b1;
      if (err_cnt_d != ERR_MAX) begin
        err_cnt_d = err_cnt_d + 1'b1;
      end
    end
  end

  // Storage is not reset; the masked head and zeroed occupancy hide its contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control state with synchronous reset; reset also discards any input presented alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

endmodule

// File: tb/tb_calc_dec.sv
// Self-checking bench for calc_dec: directed test-plan steps followed by random traffic,
// all checked against a queue-based reference model. A second instance with ERR_W=2
// shares the stimulus to exercise counter saturation.
module tb_calc_dec;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, clr_err;
  logic [3:0] in_op;
  logic       in_ready, out_valid, out_illegal, err_sticky;
  logic [2:0] out_abc;
  logic [7:0] err_cnt;
  logic       in_ready2, out_valid2, out_illegal2, err_sticky2;
  logic [2:0] out_abc2;
  logic [1:0] err_cnt2;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [3:0] model_q [$];
  int         m_err8, m_err2;
  logic       m_sticky;
  logic       last_acc;
  logic [3:0] legal_ops [8];

  always #5 clk = ~clk;

  calc_dec #(.DEPTH(DEPTH), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_abc(out_abc),
    .out_illegal(out_illegal), .err_cnt(err_cnt), .err_sticky(err_sticky), .clr_err(clr_err)
  );

  calc_dec #(.DEPTH(DEPTH), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
    .out_valid(out_valid2), .out_ready(out_ready), .out_abc(out_abc2),
    .out_illegal(out_illegal2), .err_cnt(err_cnt2), .err_sticky(err_sticky2), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model decode: position of the opcode in the legal table is the button triple
  function automatic logic [3:0] model_decode(input logic [3:0] op);
    for (int i = 0; i < 8; i++) begin
      if (legal_ops[i] == op) return {1'b0, 3'(i)};
    end
    return 4'b1000;
  endfunction

  // One clock: drive inputs, compare outputs with the model, advance the model over the edge
  task automatic cycle(input logic v, input logic [3:0] op, input logic ordy,
                       input logic clr, input logic r);
    logic       exp_valid, exp_ready;
    logic [3:0] head, e;
    in_valid = v; in_op = op; out_ready = ordy; clr_err = clr; rst = r;
    #1;
    exp_valid = (model_q.size() != 0);
    exp_ready = (model_q.size() < DEPTH);
    head      = exp_valid ? model_q[0] : 4'b0000;
    check("out_valid",   32'(out_valid),   32'(exp_valid));
    check("in_ready",    32'(in_ready),    32'(exp_ready));
    check("out_abc",     32'(out_abc),     32'(head[2:0]));
    check("out_illegal", 32'(out_illegal), 32'(head[3]));
    check("err_cnt",     32'(err_cnt),     32'(m_err8));
    check("err_sticky",  32'(err_sticky),  32'(m_sticky));
    check("err_cnt_w2",  32'(err_cnt2),    32'(m_err2));
    check("out_abc_w2",  32'(out_abc2),    32'(head[2:0]));
    last_acc = v && exp_ready && !r;
    if (r) begin
      model_q.delete();
      m_err8 = 0; m_err2 = 0; m_sticky = 1'b0;
    end else begin
      if (exp_valid && ordy) void'(model_q.pop_front());
      if (clr) begin
        m_err8 = 0; m_err2 = 0; m_sticky = 1'b0;
      end
      if (last_acc) begin
        e = model_decode(op);
        model_q.push_back(e);
        if (e[3]) begin
          m_sticky = 1'b1;
          if (m_err8 < 255) m_err8++;
          if (m_err2 < 3)   m_err2++;
        end
      end
    end
    $display("cyc t=%0t v=%0b op=%h ordy=%0b clr=%0b rst=%0b acc=%0b occ=%0d err=%0d",
             $time, v, op, ordy, clr, r, last_acc, model_q.size(), m_err8);
    @(posedge clk);
    #1;
  endtask

  // Present an opcode until accepted, with a cycle budget
  task automatic send(input logic [3:0] op, input logic ordy, input logic clr);
    for (int n = 0; n < 16; n++) begin
      cycle(1'b1, op, ordy, clr, 1'b0);
      if (last_acc) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 16; n++) begin
      if (model_q.size() == 0) return;
      cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    end
    check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    legal_ops[0] = 4'h2; legal_ops[1] = 4'h0; legal_ops[2] = 4'hD; legal_ops[3] = 4'h9;
    legal_ops[4] = 4'h6; legal_ops[5] = 4'h1; legal_ops[6] = 4'h7; legal_ops[7] = 4'hA;
    m_err8 = 0; m_err2 = 0; m_sticky = 1'b0; last_acc = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_op = 4'h0; out_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_abc",    32'(out_abc),    32'd0);
    check("rst_err_cnt",    32'(err_cnt),    32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);

    // Legal sweep: each triple appears one cycle after its accept
    for (int i = 0; i < 8; i++) begin
      send(legal_ops[i], 1'b1, 1'b0);
      check("sweep_abc", 32'(out_abc), 32'(i));
      check("sweep_ill", 32'(out_illegal), 32'd0);
    end
    drain();
    check("sweep_err", 32'(err_cnt), 32'd0);

    // Backpressure: two accepted, third refused while full
    cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
    check("bp_refused", 32'(last_acc), 32'd0);
    check("bp_head", 32'(out_abc), 32'd0);
    send(4'hD, 1'b1, 1'b0);
    drain();

    // Illegal handling
    send(4'h3, 1'b1, 1'b0);
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_abc",  32'(out_abc),     32'd0);
    send(4'hF, 1'b1, 1'b0);
    check("ill_flag2", 32'(out_illegal), 32'd1);
    drain();
    check("ill_cnt",    32'(err_cnt),    32'd2);
    check("ill_sticky", 32'(err_sticky), 32'd1);

    // Clear colliding with an illegal accept, then clear alone
    send(4'hB, 1'b1, 1'b1);
    check("coll_cnt",    32'(err_cnt),    32'd1);
    check("coll_sticky", 32'(err_sticky), 32'd1);
    cycle(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    check("clr_cnt",    32'(err_cnt),    32'd0);
    check("clr_sticky", 32'(err_sticky), 32'd0);

    // Saturation on the narrow counter
    for (int i = 0; i < 5; i++) send(4'h4, 1'b1, 1'b0);
    drain();
    check("sat_w2", 32'(err_cnt2), 32'd3);
    check("sat_w8", 32'(err_cnt),  32'd5);

    // Reset while full, then first opcode after reset
    cycle(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_ready", 32'(in_ready),  32'd1);
    check("mrst_err",   32'(err_cnt),   32'd0);
    send(4'h7, 1'b1, 1'b0);
    check("mrst_abc", 32'(out_abc), 32'b110);
    drain();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 1) == 0) ? legal_ops[$urandom_range(0, 7)] : 4'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), op, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
